buyruk_anabellek_denetleyicisi: RTL and testbench

Refill engine between the instruction cache and main memory. On a cache miss it latches the 16-byte-aligned block address and issues four 32-bit word reads to main memory. It assembles the returned words into one 128-bit block and delivers it to the instruction cache with a single-cycle completion pulse. It sits beside the fetch stage, which holds the program counter on `adres_i` until the pulse.

---
 rtl/buyruk_anabellek_denetleyicisi_pkg.sv | 17 +
 rtl/buyruk_anabellek_denetleyicisi.sv | 121 ++++++++++++
 tb/tb_buyruk_anabellek_denetleyicisi.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/buyruk_anabellek_denetleyicisi_pkg.sv
// Shared constants and state encoding for the instruction-cache refill engine.
package buyruk_anabellek_denetleyicisi_pkg;

    localparam int OBEK_GENISLIGI       = 128;
    localparam int KELIME_GENISLIGI     = 32;
    localparam int OBEK_KELIME_SAYISI   = 4;
    localparam int OBEK_OFSET_GENISLIGI = 4;

    typedef enum logic [2:0] {
        BOSTA,
        GONDER,
        BEKLE,
        TAMAM,
        IPTAL_BOSALT
    } durum_t;

endpackage

// File: rtl/buyruk_anabellek_denetleyicisi.sv
// Refill engine: fetches one 16-byte block as four word reads from main memory
// and hands it to the instruction cache with a one-cycle completion pulse.
module buyruk_anabellek_denetleyicisi
    import buyruk_anabellek_denetleyicisi_pkg::*;
#(
    parameter int AZAMI_BEKLEYEN = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         istek_i,
    input  logic [31:0]  adres_i,
    input  logic         iptal_i,
    output logic         mesgul_o,
    output logic [127:0] buyruk_obegi_o,
    output logic         anabellekten_obek_geldi_o,
    output logic [31:0]  bellek_adres_o,
    output logic         bellek_oku_o,
    input  logic         bellek_hazir_i,
    input  logic [31:0]  bellek_veri_i,
    input  logic         bellek_veri_gecerli_i
);

    localparam logic [2:0] AZAMI      = 3'(AZAMI_BEKLEYEN);
    localparam logic [2:0] KELIME_SAY = 3'(OBEK_KELIME_SAYISI);

    durum_t      durum_reg, durum_next;
    logic [27:0] taban_reg, taban_next;
    logic [2:0]  verilen_reg, verilen_next;
    logic [2:0]  alinan_reg, alinan_next;
    logic [2:0]  bekleyen;
    logic        kabul, yanit, yakala;
    logic        adres_unused;

    assign adres_unused = &{1'b0, adres_i[OBEK_OFSET_GENISLIGI-1:0]};
    assign bekleyen     = verilen_reg - alinan_reg;
    // Data with nothing outstanding is not ours to keep.
    assign yanit        = bellek_veri_gecerli_i && (bekleyen != 3'd0);

    assign mesgul_o                  = (durum_reg != BOSTA);
    assign anabellekten_obek_geldi_o = (durum_reg == TAMAM);

    always_comb begin
        durum_next     = durum_reg;
        taban_next     = taban_reg;
        verilen_next   = verilen_reg;
        alinan_next    = alinan_reg;
        bellek_oku_o   = 1'b0;
        bellek_adres_o = {taban_reg, 4'b0000};
        kabul          = 1'b0;
        yakala         = 1'b0;
        case (durum_reg)
            BOSTA: begin
                if (istek_i && !iptal_i) begin
                    taban_next   = adres_i[31:4];
                    verilen_next = 3'd0;
                    alinan_next  = 3'd0;
                    durum_next   = GONDER;
                end
            end
            GONDER, BEKLE: begin
                if (iptal_i) begin
                    // Flush beats a coincident last beat: the word is dropped and no pulse follows.
                    if (yanit) alinan_next = alinan_reg + 3'd1;
                    durum_next = (bekleyen == {2'b00, yanit}) ? BOSTA : IPTAL_BOSALT;
                end else begin
                    if (durum_reg == GONDER && verilen_reg < KELIME_SAY && bekleyen < AZAMI) begin
                        bellek_oku_o   = 1'b1;
                        bellek_adres_o = {taban_reg, verilen_reg[1:0], 2'b00};
                        kabul          = bellek_hazir_i;
                    end
                    if (kabul) verilen_next = verilen_reg + 3'd1;
                    if (yanit) begin
                        yakala      = 1'b1;
                        alinan_next = alinan_reg + 3'd1;
                    end
                    if (yanit && alinan_reg == 3'd3)
                        durum_next = TAMAM;
                    else if (kabul && verilen_reg == 3'd3)
                        durum_next = BEKLE;
                end
            end
            TAMAM: durum_next = BOSTA;
            IPTAL_BOSALT: begin
                if (yanit) begin
                    alinan_next = alinan_reg + 3'd1;
                    if (bekleyen == 3'd1) durum_next = BOSTA;
                end
            end
            default: durum_next = BOSTA;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            durum_reg   <= BOSTA;
            taban_reg   <= '0;
            verilen_reg <= '0;
            alinan_reg  <= '0;
        end else begin
            durum_reg   <= durum_next;
            taban_reg   <= taban_next;
            verilen_reg <= verilen_next;
            alinan_reg  <= alinan_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < OBEK_KELIME_SAYISI; gi++) begin : g_kelime
            logic [KELIME_GENISLIGI-1:0] kelime_reg;
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i)
                    kelime_reg <= '0;
                else if (yakala && alinan_reg[1:0] == 2'(gi))
                    kelime_reg <= bellek_veri_i;
            end
            assign buyruk_obegi_o[gi*KELIME_GENISLIGI +: KELIME_GENISLIGI] = kelime_reg;
        end
    endgenerate

endmodule

// File: tb/tb_buyruk_anabellek_denetleyicisi.sv
// Bench for the refill engine: two instances (up to 4 and up to 1 outstanding) with in-order memory models.
module tb_buyruk_anabellek_denetleyicisi;

    typedef struct {
        logic [31:0] a;
        int          due;
    } bekleyen_t;

    typedef struct {
        logic [31:0]  adres;
        logic [31:0]  veri_taban;
        int           gap;
        int           lat;
        logic [127:0] blok;
        int           cyc;
    } vektor_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         istek [2];
    logic         iptal [2];
    logic [31:0]  adres [2];
    logic         mesgul [2];
    logic         pulse [2];
    logic         oku [2];
    logic         hazir [2];
    logic         gecerli [2];
    logic [31:0]  b_adres [2];
    logic [127:0] obek [2];
    int           gap [2];
    int           lat [2];
    logic [31:0]  base [2];

    logic [31:0]  bek_adres [$];
    logic [127:0] bek_blok [$];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            logic        hazir_l, gecerli_l;
            logic [31:0] veri_l;
            int          stall_cnt, cyc;
            bekleyen_t   q [$];

            assign hazir_l      = (stall_cnt >= gap[gi]);
            assign hazir[gi]    = hazir_l;
            assign gecerli[gi]  = gecerli_l;

            buyruk_anabellek_denetleyicisi #(.AZAMI_BEKLEYEN(gi == 0 ? 4 : 1)) u_dut (
                .clk_i                     (clk),
                .rst_i                     (rst_n),
                .istek_i                   (istek[gi]),
                .adres_i                   (adres[gi]),
                .iptal_i                   (iptal[gi]),
                .mesgul_o                  (mesgul[gi]),
                .buyruk_obegi_o            (obek[gi]),
                .anabellekten_obek_geldi_o (pulse[gi]),
                .bellek_adres_o            (b_adres[gi]),
                .bellek_oku_o              (oku[gi]),
                .bellek_hazir_i            (hazir_l),
                .bellek_veri_i             (veri_l),
                .bellek_veri_gecerli_i     (gecerli_l)
            );

            // In-order memory: data for an accept becomes visible lat cycles later; reset drops everything.
            always @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q.delete();
                    stall_cnt <= 0;
                    cyc       <= 0;
                    gecerli_l <= 1'b0;
                    veri_l    <= '0;
                end else begin
                    cyc <= cyc + 1;
                    if (oku[gi] && hazir_l) begin
                        q.push_back('{b_adres[gi], cyc + lat[gi] - 1});
                        stall_cnt <= 0;
                    end else if (oku[gi]) begin
                        stall_cnt <= stall_cnt + 1;
                    end
                    if (q.size() > 0 && q[0].due <= cyc) begin
                        gecerli_l <= 1'b1;
                        veri_l    <= base[gi] + {30'b0, q[0].a[3:2]};
                        void'(q.pop_front());
                    end else begin
                        gecerli_l <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    // Scoreboard/monitor: sampled mid-cycle, i.e. the values the next rising edge acts on.
    int         out_cnt [2] = '{0, 0};
    logic       prev_stall [2] = '{1'b0, 1'b0};
    logic [31:0] prev_adr [2];
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                out_cnt[i]    = 0;
                prev_stall[i] = 1'b0;
            end else begin
                if (prev_stall[i] && !iptal[i]) begin
                    chk("stall_hold_valid", oku[i], 1'b1);
                    chk("stall_hold_addr", b_adres[i], prev_adr[i]);
                end
                if (oku[i]) chk("outstanding_limit", out_cnt[i] < (i == 0 ? 4 : 1), 1'b1);
                if (oku[i] && hazir[i]) begin
                    if (bek_adres.size() == 0) chk("unexpected_read", b_adres[i], 128'hFFFF_FFFF_FFFF);
                    else chk("read_addr", b_adres[i], bek_adres.pop_front());
                end
                if (pulse[i]) begin
                    if (bek_blok.size() == 0) chk("unexpected_pulse", pulse[i], 1'b0);
                    else chk("block", obek[i], bek_blok.pop_front());
                end
                prev_stall[i] = oku[i] && !hazir[i];
                prev_adr[i]   = b_adres[i];
                out_cnt[i]    = out_cnt[i] + int'(oku[i] && hazir[i]) - int'(gecerli[i]);
            end
        end
    end

    task automatic run_refill(input int i, input logic [31:0] adr, input logic [31:0] b,
                              input int g, input int l, input logic [127:0] blk, input int exp_cyc);
        int found;
        @(posedge clk); #1;
        gap[i]  = g;
        lat[i]  = l;
        base[i] = b;
        for (int k = 0; k < 4; k++) bek_adres.push_back({adr[31:4], 4'b0000} + 32'(4 * k));
        bek_blok.push_back(blk);
        adres[i] = adr;
        istek[i] = 1'b1;
        @(posedge clk);
        found = 0;
        for (int c = 1; c <= 80; c++) begin
            #2;
            if (c == 1) chk("read_latency", oku[i], 1'b1);
            if (pulse[i]) begin
                found = c;
                break;
            end
            @(posedge clk);
        end
        chk("pulse_seen", found != 0, 1'b1);
        chk("pulse_cycle", found, exp_cyc);
        istek[i] = 1'b0;
        @(posedge clk); #2;
        chk("idle_after_pulse", mesgul[i], 1'b0);
        $display("refill inst=%0d adres=%08h pulse_cycle=%0d block=%032h", i, adr, found, obek[i]);
    endtask

    vektor_t tablo [4];

    initial begin
        for (int i = 0; i < 2; i++) begin
            istek[i] = 1'b0; iptal[i] = 1'b0; adres[i] = '0;
            gap[i] = 0; lat[i] = 1; base[i] = '0;
        end
        tablo[0] = '{32'h0000_1238, 32'h0000_00A0, 0, 1, 128'h000000A3_000000A2_000000A1_000000A0, 6};
        tablo[1] = '{32'h0000_ABCC, 32'h0000_0055, 3, 1, 128'h00000058_00000057_00000056_00000055, 18};
        tablo[2] = '{32'hFFFF_FFF4, 32'h0000_1000, 0, 3, 128'h00001003_00001002_00001001_00001000, 8};
        tablo[3] = '{32'h8000_0040, 32'hDEAD_0000, 1, 2, 128'hDEAD0003_DEAD0002_DEAD0001_DEAD0000, 11};

        repeat (3) @(posedge clk);
        #2;
        chk("rst_mesgul", mesgul[0], 1'b0);
        chk("rst_pulse", pulse[0], 1'b0);
        chk("rst_oku", oku[0], 1'b0);
        chk("rst_adres", b_adres[0], 32'h0);
        chk("rst_obek", obek[0], 128'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int v = 0; v < 4; v++)
            run_refill(0, tablo[v].adres, tablo[v].veri_taban, tablo[v].gap, tablo[v].lat,
                       tablo[v].blok, tablo[v].cyc);

        // At most one outstanding, slow memory.
        run_refill(1, 32'h0000_3008, 32'h0000_0070, 0, 5, 128'h00000073_00000072_00000071_00000070, 25);

        // Request together with flush in idle: nothing starts.
        @(posedge clk); #1;
        istek[0] = 1'b1; iptal[0] = 1'b1; adres[0] = 32'h0000_7770;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #2;
            chk("idle_flush_ignored", mesgul[0], 1'b0);
        end
        istek[0] = 1'b0; iptal[0] = 1'b0;

        // Flush after two accepts, nothing returned yet.
        @(posedge clk); #1;
        gap[0] = 0; lat[0] = 6; base[0] = 32'h0000_0E00;
        bek_adres.push_back(32'h0000_4000);
        bek_adres.push_back(32'h0000_4004);
        adres[0] = 32'h0000_4000; istek[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        iptal[0] = 1'b1; istek[0] = 1'b0;
        #1;
        chk("flush_stops_issue", oku[0], 1'b0);
        @(posedge clk); #1;
        iptal[0] = 1'b0;
        #1;
        chk("flush_drain_busy", mesgul[0], 1'b1);
        for (int k = 0; k < 30 && mesgul[0]; k++) begin
            @(posedge clk); #2;
        end
        chk("flush_drain_done", mesgul[0], 1'b0);
        chk("flush_reads_consumed", bek_adres.size(), 0);
        $display("flush after 2 accepts: drained, mesgul=%0b", mesgul[0]);
        run_refill(0, 32'h0000_2000, 32'h0000_00C0, 0, 1, 128'h000000C3_000000C2_000000C1_000000C0, 6);

        // Flush coincident with the 4th data beat.
        @(posedge clk); #1;
        gap[0] = 0; lat[0] = 1; base[0] = 32'h0000_0B00;
        for (int k = 0; k < 4; k++) bek_adres.push_back(32'h0000_6000 + 32'(4 * k));
        adres[0] = 32'h0000_6004; istek[0] = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        iptal[0] = 1'b1; istek[0] = 1'b0;
        #1;
        chk("last_beat_busy", mesgul[0], 1'b1);
        @(posedge clk); #1;
        iptal[0] = 1'b0;
        #1;
        chk("last_beat_flush_idle", mesgul[0], 1'b0);
        chk("last_beat_no_pulse", pulse[0], 1'b0);
        repeat (3) @(posedge clk);
        $display("flush on last beat: mesgul=%0b pulse=%0b", mesgul[0], pulse[0]);

        // Asynchronous reset while stalled in GONDER.
        @(posedge clk); #1;
        gap[0] = 3; lat[0] = 1;
        adres[0] = 32'h0000_5554; istek[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3;
        chk("pre_reset_busy", oku[0], 1'b1);
        rst_n = 1'b0; istek[0] = 1'b0;
        #1;
        chk("async_rst_mesgul", mesgul[0], 1'b0);
        chk("async_rst_oku", oku[0], 1'b0);
        chk("async_rst_adres", b_adres[0], 32'h0);
        chk("async_rst_pulse", pulse[0], 1'b0);
        chk("async_rst_obek", obek[0], 128'h0);
        $display("async reset: mesgul=%0b oku=%0b adres=%08h", mesgul[0], oku[0], b_adres[0]);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_refill(0, 32'h0000_0000, 32'h0000_0020, 0, 1, 128'h00000023_00000022_00000021_00000020, 6);

        repeat (3) @(posedge clk);
        chk("reads_all_seen", bek_adres.size(), 0);
        chk("pulses_all_seen", bek_blok.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
